// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: per-stage barrier widths,
// control-vector bit positions and the bubble constant.
package pipeline_pkg;

  localparam int IFID_DATA_W  = 96;
  localparam int IFID_CTRL_W  = 12;
  localparam int IDEX_DATA_W  = 96;
  localparam int IDEX_CTRL_W  = 12;
  localparam int EXMEM_DATA_W = 96;
  localparam int EXMEM_CTRL_W = 12;
  localparam int MEMWB_DATA_W = 96;
  localparam int MEMWB_CTRL_W = 12;

  localparam int STALL_CNT_W_DEF = 16;

  localparam int CTRL_ALUOP_LSB = 0;
  localparam int CTRL_ALUOP_W   = 3;
  localparam int CTRL_ALUSRC    = 3;
  localparam int CTRL_MEMWRITE  = 4;
  localparam int CTRL_MEMREAD   = 5;
  localparam int CTRL_MEMTOREG  = 6;
  localparam int CTRL_REGWRITE  = 7;
  localparam int CTRL_JUMP      = 8;
  localparam int CTRL_BRANCH    = 9;

  localparam logic [IDEX_CTRL_W-1:0] CTRL_BUBBLE = '0;

  // Encoding is {main_valid, skid_valid}.
  typedef enum logic [1:0] {
    ST_EMPTY   = 2'b00,
    ST_ILLEGAL = 2'b01,
    ST_ONE     = 2'b10,
    ST_FULL    = 2'b11
  } slot_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-high reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;
  logic         w_max;

  assign w_max   = &r_count;
  assign o_count = r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_count <= '0;
    else if (i_inc && !w_max)
      r_count <= r_count + W'(1);
  end

endmodule

// File: rtl/pipeline_skid_barrier.sv
// Valid/ready pipeline barrier with a 2-entry skid buffer,
// flush-to-bubble and a saturating stall counter.
module pipeline_skid_barrier
  import pipeline_pkg::*;
#(
  parameter int DATA_W      = IDEX_DATA_W,
  parameter int CTRL_W      = IDEX_CTRL_W,
  parameter int STALL_CNT_W = STALL_CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  input  logic [CTRL_W-1:0]      in_ctrl,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [CTRL_W-1:0]      out_ctrl,
  output logic [STALL_CNT_W-1:0] stall_count
);

  logic              r_main_valid;
  logic              r_skid_valid;
  logic [DATA_W-1:0] r_main_data;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_skid_data;
  logic [CTRL_W-1:0] r_skid_ctrl;

  slot_state_e w_state;
  logic        w_accept;
  logic        w_pop;
  logic        w_nxt_main_valid;
  logic        w_nxt_skid_valid;
  logic        w_ld_main_in;
  logic        w_ld_main_skid;
  logic        w_ld_skid;

  assign w_state  = slot_state_e'({r_main_valid, r_skid_valid});
  assign in_ready = !r_skid_valid && !rst;
  assign w_accept = in_valid && in_ready && !flush;
  assign w_pop    = out_valid && out_ready;

  assign out_valid = r_main_valid;
  assign out_data  = r_main_data;
  assign out_ctrl  = r_main_valid ? r_main_ctrl
                                  : CTRL_W'(CTRL_BUBBLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else begin
      r_main_valid <= w_nxt_main_valid;
      r_skid_valid <= w_nxt_skid_valid;
    end
  end

  always_comb begin
    w_nxt_main_valid = r_main_valid;
    w_nxt_skid_valid = r_skid_valid;
    if (flush) begin
      w_nxt_main_valid = 1'b0;
      w_nxt_skid_valid = 1'b0;
    end else begin
      case (w_state)
        ST_EMPTY: begin
          if (w_accept) w_nxt_main_valid = 1'b1;
        end
        ST_ONE: begin
          if (w_accept && !w_pop)
            w_nxt_skid_valid = 1'b1;
          else if (!w_accept && w_pop)
            w_nxt_main_valid = 1'b0;
        end
        ST_FULL: begin
          if (w_pop) w_nxt_skid_valid = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;
    if (!flush) begin
      case (w_state)
        ST_EMPTY: w_ld_main_in = w_accept;
        ST_ONE: begin
          w_ld_main_in = w_accept && w_pop;
          w_ld_skid    = w_accept && !w_pop;
        end
        ST_FULL:  w_ld_main_skid = w_pop;
        default: ;
      endcase
    end
  end

  // Payload registers carry no reset; validity lives in the flags.
  always_ff @(posedge clk) begin
    if (w_ld_main_in) begin
      r_main_data <= in_data;
      r_main_ctrl <= in_ctrl;
    end else if (w_ld_main_skid) begin
      r_main_data <= r_skid_data;
      r_main_ctrl <= r_skid_ctrl;
    end
    if (w_ld_skid) begin
      r_skid_data <= in_data;
      r_skid_ctrl <= in_ctrl;
    end
  end

  sat_counter #(
    .W(STALL_CNT_W)
  ) u_stall_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_inc  (out_valid && !out_ready),
    .o_count(stall_count)
  );

  a_no_orphan_skid: assert property (
    @(posedge clk) disable iff (rst)
    w_state != ST_ILLEGAL
  );

endmodule

// File: tb/tb_pipeline_skid_barrier.sv
// Directed bench for pipeline_skid_barrier: reset, streaming,
// backpressure, flush, counter saturation and async reset.
module tb_pipeline_skid_barrier;

  localparam int DW = 96;
  localparam int CW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [15:0]   stall_count;

  logic          in_ready4;
  logic          out_valid4;
  logic [DW-1:0] out_data4;
  logic [CW-1:0] out_ctrl4;
  logic [3:0]    stall_count4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipeline_skid_barrier #(
    .DATA_W(DW), .CTRL_W(CW), .STALL_CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ctrl(out_ctrl),
    .stall_count(stall_count)
  );

  pipeline_skid_barrier #(
    .DATA_W(DW), .CTRL_W(CW), .STALL_CNT_W(4)
  ) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready4),
    .in_data(in_data), .in_ctrl(in_ctrl),
    .flush(flush),
    .out_valid(out_valid4), .out_ready(out_ready),
    .out_data(out_data4), .out_ctrl(out_ctrl4),
    .stall_count(stall_count4)
  );

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d,
                       input logic [CW-1:0] c);
    in_valid = v;
    in_data  = d;
    in_ctrl  = c;
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 96'h55, 12'h003);

    // reset held for 3 cycles with in_valid high
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_ctrl", out_ctrl, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_stall", stall_count, 0);
    end
    rst = 1'b0;
    drive(1'b0, '0, '0);
    step();
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);

    // streaming 1..8
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, DW'(i), CW'(i + 12'h100));
      step();
      chk("stream_valid", out_valid, 1);
      chk("stream_data", out_data, i);
      chk("stream_ctrl", out_ctrl, i + 12'h100);
      chk("stream_in_ready", in_ready, 1);
    end
    drive(1'b0, '0, '0);
    step();
    chk("stream_drain_valid", out_valid, 0);
    chk("stream_drain_ctrl", out_ctrl, 0);
    chk("stream_stall", stall_count, 0);

    // backpressure: A accepted, then B while stalled
    drive(1'b1, 96'hA, 12'h01A);
    step();
    chk("bp_a_data", out_data, 96'hA);
    out_ready = 1'b0;
    drive(1'b1, 96'hB, 12'h01B);
    step();
    chk("bp_full_in_ready", in_ready, 0);
    chk("bp_full_data", out_data, 96'hA);
    chk("bp_stall1", stall_count, 1);
    drive(1'b0, '0, '0);
    step();
    step();
    chk("bp_hold_data", out_data, 96'hA);
    chk("bp_hold_ctrl", out_ctrl, 12'h01A);
    chk("bp_hold_in_ready", in_ready, 0);
    chk("bp_stall3", stall_count, 3);
    out_ready = 1'b1;
    step();
    chk("bp_b_valid", out_valid, 1);
    chk("bp_b_data", out_data, 96'hB);
    chk("bp_b_ctrl", out_ctrl, 12'h01B);
    chk("bp_release_in_ready", in_ready, 1);
    step();
    chk("bp_empty", out_valid, 0);
    chk("bp_stall_final", stall_count, 3);

    // fill to FULL then flush with a live incoming instruction
    drive(1'b1, 96'hC, 12'h00C);
    step();
    out_ready = 1'b0;
    drive(1'b1, 96'hD, 12'h00D);
    step();
    chk("fl_full_in_ready", in_ready, 0);
    drive(1'b1, 96'hE, 12'hFFF);
    flush = 1'b1;
    step();
    chk("fl_out_valid", out_valid, 0);
    chk("fl_out_ctrl", out_ctrl, 0);
    chk("fl_in_ready", in_ready, 1);
    chk("fl_stall", stall_count, 5);
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, '0, '0);
    step();
    chk("fl_nothing_after", out_valid, 0);

    // acceptance resumes after flush
    drive(1'b1, 96'h77, 12'h005);
    step();
    chk("post_fl_data", out_data, 96'h77);
    chk("post_fl_ctrl", out_ctrl, 12'h005);
    drive(1'b0, '0, '0);
    step();

    // flush while EMPTY with in_valid && in_ready: nothing accepted
    drive(1'b1, 96'h66, 12'h0F0);
    flush = 1'b1;
    step();
    chk("fl_empty_valid", out_valid, 0);
    chk("fl_empty_ctrl", out_ctrl, 0);
    flush = 1'b0;
    drive(1'b0, '0, '0);
    step();
    chk("fl_empty_after", out_valid, 0);

    // saturation: both counters are at 5 here
    drive(1'b1, 96'h99, 12'h099);
    step();
    drive(1'b0, '0, '0);
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("sat4_at10", stall_count4, 15);
    chk("sat16_at10", stall_count, 15);
    for (int i = 0; i < 10; i++) step();
    chk("sat4_at20", stall_count4, 15);
    chk("sat16_at20", stall_count, 25);
    chk("sat_hold_data", out_data, 96'h99);

    // async reset mid-cycle while FULL
    drive(1'b1, 96'hAA, 12'h0AA);
    step();
    chk("ar_full_in_ready", in_ready, 0);
    chk("ar_stall_pre", stall_count, 26);
    drive(1'b0, '0, '0);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_out_valid", out_valid, 0);
    chk("ar_out_ctrl", out_ctrl, 0);
    chk("ar_in_ready", in_ready, 0);
    chk("ar_stall", stall_count, 0);
    chk("ar_stall4", stall_count4, 0);
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    chk("ar_after_in_ready", in_ready, 1);
    chk("ar_after_valid", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
